// File: rtl/ps2_scancode_rx_if.sv
// PS/2 pin pair plus the decoded make-code record handed to ps2ascii.
// master: keyboard/consumer side; slave: the receiver.
interface ps2_scancode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] byte_ps2;
  logic       extend;
  logic       shift;
  logic       code_valid;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  byte_ps2,
    input  extend,
    input  shift,
    input  code_valid,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output byte_ps2,
    output extend,
    output shift,
    output code_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix and shift tracking.
// Emits one strobed {byte_ps2, extend, shift} record per key make event.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst,
  ps2_scancode_rx_if.slave  bus
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic          data_bit;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          ext_pend;
  logic          brk_pend;
  logic          lshift;
  logic          rshift;

  logic [7:0]    byte_r;
  logic          extend_r;
  logic          shift_r;
  logic          code_valid_r;
  logic          frame_err_r;

  logic [7:0]    rx_byte;
  logic          frame_good;
  logic          is_shift;
  logic          is_ctrl;

  // Synchronizers and glitch filter both idle high, matching the released bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], bus.ps2_clk};
      data_sync  <= {data_sync[0], bus.ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign data_bit = data_sync[1];

  always_comb begin
    rx_byte    = shreg[7:0];
    frame_good = (^shreg[8:0]) & shreg[9];
    is_shift   = (rx_byte == 8'h12) || (rx_byte == 8'h59);
    is_ctrl    = 1'b0;
    case (rx_byte)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ctrl = 1'b1;
      default:                                  is_ctrl = 1'b0;
    endcase
  end

  // The decoder acts in the CHECK cycle so its registered strobe lands while
  // the FSM is already back in IDLE, ready for a back-to-back start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      to_cnt       <= '0;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      lshift       <= 1'b0;
      rshift       <= 1'b0;
      byte_r       <= '0;
      extend_r     <= 1'b0;
      shift_r      <= 1'b0;
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;

      if (fall || state != RECV) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (fall && !data_bit) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end

        RECV: begin
          if (fall) begin
            shreg <= {data_bit, shreg[9:1]};
            if (bit_cnt == 4'd9) state <= CHECK;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            shreg       <= '0;
            frame_err_r <= 1'b1;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
          end
        end

        CHECK: begin
          state <= IDLE;
          if (!frame_good) begin
            frame_err_r <= 1'b1;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext_pend <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (is_shift) begin
              if (!ext_pend) begin
                if (rx_byte == 8'h12) lshift <= !brk_pend;
                else                  rshift <= !brk_pend;
              end
            end else if (!is_ctrl && !brk_pend) begin
              byte_r       <= rx_byte;
              extend_r     <= ext_pend;
              shift_r      <= lshift | rshift;
              code_valid_r <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ps2   = byte_r;
  assign bus.extend     = extend_r;
  assign bus.shift      = shift_r;
  assign bus.code_valid = code_valid_r;
  assign bus.frame_err  = frame_err_r;

endmodule
